ntt_loader: RTL and testbench
=============================

# ntt_loader

Front-end feeder for `ntt_processor`: accepts one polynomial as a valid/ready stream of 2048 packed 60-bit words and drives the processor's `write_enable`/`address_in`/`data_in` load port. After the last word it issues a single-cycle `start`, supervises the run until the output burst completes, and flags length or timing faults. It sits between the host/DMA stream and the processor and serialises loads against processor activity.

## Interface
- `LOG_CORE_COUNT`, default 5, log2 of the processor core count. Sets the expected output-burst length.
- `WORDS`, default 2048, number of 60-bit words per polynomial. The address is `$clog2(WORDS)` = 11 bits.
- `TIMEOUT_CYCLES`, default 8192, maximum number of cycles from `start` to the end of the output burst.
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous, active-high reset.
- `s_data`  in  60  two packed 30-bit coefficients per word.
- `s_valid`  in  1  stream word valid.
- `s_last`  in  1  marks the final word of a polynomial.
- `s_ready`  out  1  loader accepts a word.
- `nt_write_enable`  out  1  drives the processor's `write_enable`.
- `nt_address_in`  out  11  drives the processor's `address_in`.
- `nt_data_in`  out  60  drives the processor's `data_in`.
- `nt_start`  out  1  one-cycle start pulse to the processor.
- `nt_output_active`  in  1  processor output-burst indicator.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when a run completes.
- `err_len`  out  1  sticky; set when `s_last` does not fall on word `WORDS-1`.
- `err_timeout`  out  1  sticky; set on timeout or a wrong burst length.

## Operation
- States: IDLE, LOAD, GAP, START, RUN_WAIT, RUN_OUT, DONE.
- IDLE
  - `s_ready = !nt_output_active`.
  - The first handshake (`s_valid && s_ready`) writes word 0, clears both sticky error flags, and moves to LOAD.
- LOAD
  - `s_ready` = 1. A word counter starts at 0 and increments by 1 per handshake.
  - Each handshake registers `nt_write_enable` = 1, `nt_address_in` = counter, `nt_data_in` = `s_data`.
  - No handshake → `nt_write_enable` = 0; address and data hold their previous values.
- End of load: either of these events moves to GAP and drops `s_ready` in the same cycle as the final handshake.
  - Handshake with counter == `WORDS-1`. If `s_last` is 0 on this word, `err_len` is set.
  - Handshake with `s_last` = 1 and counter < `WORDS-1`. `err_len` is set and the remaining processor words are left unwritten.
- GAP: one idle cycle, so the processor's registered write lands before `start`.
- START: `nt_start` = 1 for exactly one cycle, then RUN_WAIT. Arming the timeout counter also happens here.
- RUN_WAIT
  - A rising `nt_output_active` moves to RUN_OUT.
  - Timeout counter reaching `TIMEOUT_CYCLES` → set `err_timeout`, go to DONE.
- RUN_OUT
  - Counts the cycles during which `nt_output_active` is high.
  - When it falls: a count different from `1<<(10-LOG_CORE_COUNT)` (32 by default) sets `err_timeout`. Go to DONE.
  - The timeout still applies in this state.
- DONE: `done` = 1 for one cycle, then IDLE.
- `s_ready` is 0 in GAP through DONE. Stream words offered during these states are back-pressured, never dropped.
- Reset asserted mid-operation:
  - All state returns to IDLE and all outputs go to 0 immediately.
  - The processor has no reset and may still be running, so IDLE gating on `nt_output_active` blocks new loads until its burst ends.

## Timing
- Reset values: `s_ready` = 0 while `rst` is high, and 1 on the first cycle after reset if `nt_output_active` is 0. All other outputs are 0.
- Load latency: the handshake in cycle c produces the registered write on the processor port in cycle c+1.
- Full load of `WORDS` words at `s_valid` = 1 every cycle: the last handshake is in cycle L, GAP in L+1, `nt_start` in L+2.
- `nt_start` and `nt_write_enable` are never high in the same cycle.
- `done` is asserted on the cycle after `nt_output_active` falls.
- Counter widths: word counter 11 bits (saturating handling is not needed, it is bounded by the state), burst counter 11 bits, timeout counter `$clog2(TIMEOUT_CYCLES)+1` bits.

## Structure
- Shared `ntt_pkg` holds:
  - the state enum `loader_state_t`;
  - `COEFF_W` = 30 and `WORD_W` = 60;
  - `LOG_N` = 12 and `N_4` = 1024;
  - the function `out_beats(log_core_count)`.
- `ntt_loader` is a single module with no sub-modules. The burst and timeout counters are inline.

## Test plan
- Reset mid-LOAD at word 700, with `nt_output_active` = 0:
  - all outputs go to 0 immediately;
  - after reset release, a fresh 2048-word load starts at address 0.
- Continuous 2048-word stream, `s_last` on word 2047, model asserts `nt_output_active` for 32 cycles 100 cycles after start:
  - addresses 0..2047 appear in order, `nt_start` occurs 2 cycles after the last handshake, `done` pulses once, no errors.
- Random `s_valid` gaps (50%):
  - written addresses stay contiguous, and `nt_write_enable` is low on exactly the gap cycles.
- `s_last` on word 1000:
  - `err_len` = 1 and `nt_start` still issues;
  - with `s_last` missing on word 2047, `err_len` = 1 and the load ends at 2047.
- Processor never raises `nt_output_active`:
  - `err_timeout` = 1 at `TIMEOUT_CYCLES`, then `done`;
  - a burst of 31 cycles also sets `err_timeout`.
- `nt_output_active` held high while in IDLE:
  - `s_ready` = 0 until it falls.

Source files
------------

// File: rtl/ntt_pkg.sv
// Shared types and constants for the NTT front-end blocks.
package ntt_pkg;

    localparam int COEFF_W = 30;
    localparam int WORD_W  = 2 * COEFF_W;
    localparam int LOG_N   = 12;
    localparam int N_4     = 1024;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_GAP,
        ST_START,
        ST_RUN_WAIT,
        ST_RUN_OUT,
        ST_DONE
    } loader_state_t;

    // Expected length of the processor output burst for a given core count.
    function automatic logic [10:0] out_beats(input int log_core_count);
        return 11'(N_4 >> log_core_count);
    endfunction

endpackage

// File: rtl/ntt_loader.sv
// Stream-to-processor loader: writes one polynomial into ntt_processor,
// fires start, then supervises the run until the output burst ends.
//
// state       | meaning
// ------------+--------------------------------------------------------
// ST_IDLE     | waiting for first word; gated while processor still bursts
// ST_LOAD     | accepting words, one processor write per handshake
// ST_GAP      | one idle cycle so the final registered write lands
// ST_START    | single-cycle start pulse, timeout armed
// ST_RUN_WAIT | waiting for the output burst to begin
// ST_RUN_OUT  | counting burst beats until nt_output_active falls
// ST_DONE     | single-cycle done pulse
module ntt_loader
    import ntt_pkg::*;
#(
    parameter int LOG_CORE_COUNT = 5,
    parameter int WORDS          = 2048,
    parameter int TIMEOUT_CYCLES = 8192
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WORD_W-1:0]        s_data,
    input  logic                     s_valid,
    input  logic                     s_last,
    output logic                     s_ready,
    output logic                     nt_write_enable,
    output logic [$clog2(WORDS)-1:0] nt_address_in,
    output logic [WORD_W-1:0]        nt_data_in,
    output logic                     nt_start,
    input  logic                     nt_output_active,
    output logic                     busy,
    output logic                     done,
    output logic                     err_len,
    output logic                     err_timeout
);

    localparam int AW = $clog2(WORDS);
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

    localparam logic [AW-1:0] LAST_IDX = AW'(WORDS - 1);
    localparam logic [10:0]   BEATS    = out_beats(LOG_CORE_COUNT);
    localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYCLES - 1);

    loader_state_t state;
    loader_state_t state_nxt;

    logic [AW-1:0] word_cnt;
    logic [10:0]   burst_cnt;
    logic [TW-1:0] tmo_cnt;
    logic          act_q;

    logic          hs;
    logic [AW-1:0] idx;
    logic          load_end;
    logic          len_bad;
    logic          act_rise;
    logic          tmo_hit;
    logic          tmo_err;
    logic          beat_err;

    // The first word of a polynomial is accepted from IDLE and is always word 0.
    assign hs       = s_valid && s_ready;
    assign idx      = (state == ST_IDLE) ? '0 : word_cnt;
    assign load_end = hs && ((idx == LAST_IDX) || s_last);
    assign len_bad  = load_end && !((idx == LAST_IDX) && s_last);
    assign act_rise = nt_output_active && !act_q;
    assign tmo_hit  = (tmo_cnt == '0);

    // State-decoded outputs; ready is forced low while reset is held.
    always_comb begin
        s_ready  = 1'b0;
        nt_start = 1'b0;
        done     = 1'b0;
        busy     = (state != ST_IDLE);
        case (state)
            ST_IDLE:  s_ready  = !rst && !nt_output_active;
            ST_LOAD:  s_ready  = !rst;
            ST_START: nt_start = 1'b1;
            ST_DONE:  done     = 1'b1;
            default:  ;
        endcase
    end

    // Next-state logic and error strobes.
    always_comb begin
        state_nxt = state;
        tmo_err   = 1'b0;
        beat_err  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (hs) begin
                    state_nxt = load_end ? ST_GAP : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (load_end) begin
                    state_nxt = ST_GAP;
                end
            end
            ST_GAP:   state_nxt = ST_START;
            ST_START: state_nxt = ST_RUN_WAIT;
            ST_RUN_WAIT: begin
                if (tmo_hit) begin
                    tmo_err   = 1'b1;
                    state_nxt = ST_DONE;
                end else if (act_rise) begin
                    state_nxt = ST_RUN_OUT;
                end
            end
            ST_RUN_OUT: begin
                if (tmo_hit) begin
                    tmo_err   = 1'b1;
                    state_nxt = ST_DONE;
                end else if (!nt_output_active) begin
                    beat_err  = (burst_cnt != BEATS);
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Processor load port: registered write per accepted word, hold otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nt_write_enable <= 1'b0;
            nt_address_in   <= '0;
            nt_data_in      <= '0;
            word_cnt        <= '0;
        end else begin
            nt_write_enable <= hs;
            if (hs) begin
                nt_address_in <= idx;
                nt_data_in    <= s_data;
                word_cnt      <= idx + 1'b1;
            end
        end
    end

    // Sticky error flags, cleared by the first word of a new polynomial.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_len     <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            if (hs && (state == ST_IDLE)) begin
                err_len     <= len_bad;
                err_timeout <= 1'b0;
            end else begin
                if (len_bad) begin
                    err_len <= 1'b1;
                end
                if (tmo_err || beat_err) begin
                    err_timeout <= 1'b1;
                end
            end
        end
    end

    // Run supervision: timeout down-counter armed at start, burst beat counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt   <= '0;
            burst_cnt <= '0;
            act_q     <= 1'b0;
        end else begin
            act_q <= nt_output_active;
            if (state == ST_START) begin
                tmo_cnt <= TMO_LOAD;
            end else if (((state == ST_RUN_WAIT) || (state == ST_RUN_OUT)) && !tmo_hit) begin
                tmo_cnt <= tmo_cnt - 1'b1;
            end
            if ((state == ST_RUN_WAIT) && act_rise) begin
                burst_cnt <= 11'd1;
            end else if ((state == ST_RUN_OUT) && nt_output_active) begin
                burst_cnt <= burst_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ntt_loader.sv
// Directed bench for ntt_loader: load, run supervision, error and reset cases.
module tb_ntt_loader;

    localparam int TMO = 8192;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [59:0] s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_last = 1'b0;
    logic        s_ready;
    logic        nt_write_enable;
    logic [10:0] nt_address_in;
    logic [59:0] nt_data_in;
    logic        nt_start;
    logic        nt_output_active = 1'b0;
    logic        busy;
    logic        done;
    logic        err_len;
    logic        err_timeout;

    int errors = 0;
    int checks = 0;

    ntt_loader #(
        .LOG_CORE_COUNT(5),
        .WORDS(2048),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .s_data(s_data),
        .s_valid(s_valid),
        .s_last(s_last),
        .s_ready(s_ready),
        .nt_write_enable(nt_write_enable),
        .nt_address_in(nt_address_in),
        .nt_data_in(nt_data_in),
        .nt_start(nt_start),
        .nt_output_active(nt_output_active),
        .busy(busy),
        .done(done),
        .err_len(err_len),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [59:0] word_of(input int e);
        return {30'(e * 7 + 5), 30'(e + 32'h1555_0000)};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Offer words 0..n-1; each accepted word must appear on the write port next cycle.
    task automatic feed(input int n, input int last_at, input int gap_pct);
        int   e = 0;
        int   cyc = 0;
        int   bad_we = 0;
        int   bad_ad = 0;
        logic vld;
        while (e < n && cyc < 20 * n + 100) begin
            @(negedge clk);
            vld     = (gap_pct == 0) ? 1'b1 : ($urandom_range(99) >= gap_pct);
            s_valid = vld;
            s_data  = word_of(e);
            s_last  = (e == last_at);
            @(posedge clk);
            #1;
            cyc++;
            if (nt_write_enable !== vld) bad_we++;
            if (vld) begin
                if (nt_address_in !== 11'(e) || nt_data_in !== word_of(e)) bad_ad++;
                e++;
            end
        end
        chk("feed_count", 64'(e), 64'(n));
        chk("feed_we_gaps", 64'(bad_we), 64'd0);
        chk("feed_addr_data", 64'(bad_ad), 64'd0);
    endtask

    // Called in the GAP cycle; a word is still offered to prove back-pressure.
    task automatic after_load(input logic exp_len);
        chk("gap_ready", 64'(s_ready), 64'd0);
        chk("gap_start", 64'(nt_start), 64'd0);
        chk("gap_busy", 64'(busy), 64'd1);
        @(negedge clk);
        s_valid = 1'b1;
        s_last  = 1'b0;
        s_data  = 60'hABC;
        @(posedge clk);
        #1;
        chk("start_pulse", 64'(nt_start), 64'd1);
        chk("start_no_we", 64'(nt_write_enable), 64'd0);
        chk("start_ready", 64'(s_ready), 64'd0);
        chk("start_err_len", 64'(err_len), 64'(exp_len));
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    // Processor model: burst of 'beats' cycles, 'delay' cycles after start.
    task automatic proc_run(input int delay, input int beats, input logic exp_to);
        for (int i = 0; i < delay; i++) @(negedge clk);
        nt_output_active = 1'b1;
        #1;
        chk("run_ready", 64'(s_ready), 64'd0);
        chk("run_no_we", 64'(nt_write_enable), 64'd0);
        for (int i = 0; i < beats; i++) @(negedge clk);
        chk("run_no_early_done", 64'(done), 64'd0);
        nt_output_active = 1'b0;
        @(posedge clk);
        #1;
        chk("done_pulse", 64'(done), 64'd1);
        chk("done_err_timeout", 64'(err_timeout), 64'(exp_to));
        chk("done_busy", 64'(busy), 64'd1);
        @(posedge clk);
        #1;
        chk("done_single", 64'(done), 64'd0);
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_ready", 64'(s_ready), 64'd1);
    endtask

    initial begin
        int n;

        // Reset values while rst is held.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 64'(s_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_we", 64'(nt_write_enable), 64'd0);
        chk("rst_start", 64'(nt_start), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_errs", 64'({err_len, err_timeout}), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_ready", 64'(s_ready), 64'd1);

        // Reset in the middle of a load.
        feed(700, -1, 0);
        chk("mid_addr", 64'(nt_address_in), 64'd699);
        chk("mid_busy", 64'(busy), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_ready", 64'(s_ready), 64'd0);
        chk("mid_rst_we", 64'(nt_write_enable), 64'd0);
        chk("mid_rst_addr", 64'(nt_address_in), 64'd0);
        chk("mid_rst_data", 64'(nt_data_in), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst     = 1'b0;
        s_valid = 1'b0;

        // Continuous full load, nominal run.
        feed(2048, 2047, 0);
        after_load(1'b0);
        proc_run(100, 32, 1'b0);
        chk("nominal_err_len", 64'(err_len), 64'd0);

        // Random 50% valid gaps.
        feed(2048, 2047, 50);
        after_load(1'b0);
        proc_run(100, 32, 1'b0);

        // Early s_last on word 1000.
        feed(1001, 1000, 0);
        after_load(1'b1);
        proc_run(50, 32, 1'b0);
        chk("early_last_err_len", 64'(err_len), 64'd1);

        // s_last missing on word 2047.
        feed(2048, -1, 0);
        after_load(1'b1);
        proc_run(50, 32, 1'b0);

        // Processor never bursts: timeout.
        feed(2048, 2047, 0);
        after_load(1'b0);
        n = 0;
        while (done !== 1'b1 && n < TMO + 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("tmo_latency", 64'(n), 64'(TMO + 1));
        chk("tmo_err", 64'(err_timeout), 64'd1);
        @(posedge clk);
        #1;
        chk("tmo_idle", 64'(busy), 64'd0);

        // Short burst of 31 beats.
        feed(2048, 2047, 0);
        chk("short_err_cleared", 64'(err_timeout), 64'd0);
        after_load(1'b0);
        proc_run(20, 31, 1'b1);

        // Processor still bursting while idle: loads are held off.
        @(negedge clk);
        nt_output_active = 1'b1;
        s_valid = 1'b1;
        s_data  = 60'h123;
        #1;
        chk("gate_ready", 64'(s_ready), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("gate_no_we", 64'(nt_write_enable), 64'd0);
        chk("gate_busy", 64'(busy), 64'd0);
        @(negedge clk);
        nt_output_active = 1'b0;
        s_valid = 1'b0;
        #1;
        chk("gate_release", 64'(s_ready), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
